frost32_mem_responder: RTL and testbench



---
 rtl/frost32_mem_responder.sv | 150 +++++++++++++++
 tb/tb_frost32_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/frost32_mem_responder.sv
// Frost32 data-port responder: one access at a time against a word RAM after WAIT_STATES cycles.
// Optional alignment/range error checking via `define FROST32_MEM_RESPONDER_ERR_CHECK_EN.
module frost32_mem_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_mem_access,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        data_inout_access_type,
  input  logic [1:0]  data_inout_access_size,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        busy,
  output logic        err
);

  localparam int         AW        = $clog2(MEM_WORDS);
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;
  typedef enum logic [1:0] {Dias32 = 2'd0, Dias16 = 2'd1, Dias8 = 2'd2, DiasBad = 2'd3} size_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, data_out_q;
  logic        write_q, ready_q, busy_q, err_q;
  size_e       size_q;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0] op_addr, op_wdata;
  logic        op_write, op_err, do_op, mem_we;
  size_e       op_size, eff_size;
  logic [1:0]  lane;
  logic [3:0]  byte_en;
  logic [AW-1:0] word_idx;
  logic [31:0] rd_word, rd_shift, rd_val, wr_shift, wr_word, resp_data;

  // With zero wait states the access completes on the capture edge, so the
  // datapath must see the live inputs while idle and the held copy otherwise.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_write = write_q;
    op_size  = size_q;
    if (state_q == StIdle) begin
      op_addr  = addr;
      op_wdata = data_in;
      op_write = data_inout_access_type;
      op_size  = size_e'(data_inout_access_size);
    end

    eff_size = (op_size == DiasBad) ? Dias32 : op_size;
    case (eff_size)
      Dias16:  begin lane = {op_addr[1], 1'b0}; byte_en = 4'b0011 << lane; end
      Dias8:   begin lane = op_addr[1:0];       byte_en = 4'b0001 << lane; end
      default: begin lane = 2'd0;               byte_en = 4'b1111;         end
    endcase

    word_idx = op_addr[AW+1:2];
    rd_word  = mem[word_idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (eff_size)
      Dias16:  rd_val = {16'h0, rd_shift[15:0]};
      Dias8:   rd_val = {24'h0, rd_shift[7:0]};
      default: rd_val = rd_shift;
    endcase

    wr_shift = op_wdata << {lane, 3'b000};
    for (int b = 0; b < 4; b++)
      wr_word[8*b +: 8] = byte_en[b] ? wr_shift[8*b +: 8] : rd_word[8*b +: 8];

`ifdef FROST32_MEM_RESPONDER_ERR_CHECK_EN
    op_err = (op_size == Dias32 && op_addr[1:0] != 2'b00) ||
             (op_size == Dias16 && op_addr[0]) ||
             (op_size == DiasBad) ||
             (op_addr >= 32'(4 * MEM_WORDS));
`else
    op_err = 1'b0;
`endif

    do_op = (state_q == StIdle && req_mem_access && WAIT_STATES == 0) ||
            (state_q == StWait && cnt_q == LAST_WAIT);
    // Gating with rst_n keeps a reset-time zero-wait request from touching RAM.
    mem_we    = do_op && op_write && !op_err && rst_n;
    resp_data = (op_write || op_err) ? 32'h0 : rd_val;
  end

`ifndef FROST32_MEM_RESPONDER_ERR_CHECK_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^op_addr[31:AW+2];
`endif

  // NOTE: the RAM has no reset; clearing it would force flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= wr_word;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      write_q    <= 1'b0;
      size_q     <= Dias32;
      data_out_q <= 32'h0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_q <= do_op;
      err_q   <= do_op && op_err;
      if (do_op) data_out_q <= resp_data;

      case (state_q)
        StIdle: begin
          if (req_mem_access) begin
            addr_q  <= addr;
            wdata_q <= data_in;
            write_q <= data_inout_access_type;
            size_q  <= size_e'(data_inout_access_size);
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= (WAIT_STATES == 0) ? StRespond : StWait;
          end
        end
        StWait: begin
          if (cnt_q == LAST_WAIT) state_q <= StRespond;
          else                    cnt_q   <= cnt_q + 4'd1;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_ready = ready_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_frost32_mem_responder.sv
// Directed bench for frost32_mem_responder: four instances with WAIT_STATES 1, 0, 3 and 15.
module tb_frost32_mem_responder;

  logic        clk = 1'b0;
  logic        rstn [4];
  logic        req  [4];
  logic [31:0] addr_s = '0, din_s = '0;
  logic        type_s = 1'b0;
  logic [1:0]  size_s = 2'd0;
  logic [31:0] dout [4];
  logic        rdy  [4];
  logic        bsy  [4];
  logic        er   [4];

  int checks = 0;
  int failures = 0;

  localparam logic RD = 1'b0, WR = 1'b1;
  localparam logic [1:0] S32 = 2'd0, S16 = 2'd1, S8 = 2'd2, SBAD = 2'd3;

  always #5 clk = ~clk;

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : (k == 2) ? 3 : 15;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    frost32_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(ws_of(g))) u_dut (
      .clk                    (clk),
      .rst_n                  (rstn[g]),
      .req_mem_access         (req[g]),
      .addr                   (addr_s),
      .data_in                (din_s),
      .data_inout_access_type (type_s),
      .data_inout_access_size (size_s),
      .data_out               (dout[g]),
      .data_ready             (rdy[g]),
      .busy                   (bsy[g]),
      .err                    (er[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access on instance k; returns data, err and the number of
  // cycles from the capture edge until data_ready is seen (bounded at 40).
  task automatic do_access(input int k, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rdata, output logic rerr, output int lat);
    @(negedge clk);
    type_s = wr; size_s = sz; addr_s = a; din_s = d; req[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[k] = 1'b0;
    lat = 1;
    while (!rdy[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = dout[k];
    rerr  = er[k];
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  logic [31:0] held_exp [3];
  logic        saw_rdy;

  initial begin
    for (int k = 0; k < 4; k++) begin rstn[k] = 1'b0; req[k] = 1'b0; end
    #23;
    check("reset data_out", dout[0], 32'h0);
    check("reset data_ready", {31'h0, rdy[0]}, 32'h0);
    check("reset busy", {31'h0, bsy[0]}, 32'h0);
    check("reset err", {31'h0, er[3]}, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) rstn[k] = 1'b1;

    // WAIT_STATES=1: word write then read back
    do_access(0, WR, S32, 32'h10, 32'hDEADBEEF, rd, e, lat);
    check("ws1 write latency", 32'(lat), 32'd2);
    check("ws1 write data_out zero", rd, 32'h0);
    check("ws1 write busy", {31'h0, bsy[0]}, 32'h1);
    do_access(0, RD, S32, 32'h10, 32'h0, rd, e, lat);
    check("ws1 read latency", 32'(lat), 32'd2);
    check("ws1 read data", rd, 32'hDEADBEEF);
    check("ws1 read err", {31'h0, e}, 32'h0);
    @(negedge clk);
    check("ready single pulse", {31'h0, rdy[0]}, 32'h0);
    check("busy falls", {31'h0, bsy[0]}, 32'h0);
    check("data_out holds", dout[0], 32'hDEADBEEF);

    // Sub-word lanes
    do_access(0, WR, S32, 32'h20, 32'h11223344, rd, e, lat);
    do_access(0, WR, S8,  32'h22, 32'h000000AA, rd, e, lat);
    do_access(0, RD, S32, 32'h20, 32'h0, rd, e, lat);
    check("byte write merge", rd, 32'h11AA3344);
    do_access(0, RD, S16, 32'h22, 32'h0, rd, e, lat);
    check("half read upper", rd, 32'h000011AA);
    do_access(0, RD, S8, 32'h23, 32'h0, rd, e, lat);
    check("byte read lane3", rd, 32'h00000011);
    do_access(0, WR, S16, 32'h20, 32'hFFFF5A5A, rd, e, lat);
    do_access(0, RD, S32, 32'h20, 32'h0, rd, e, lat);
    check("half write lower", rd, 32'h11AA5A5A);

`ifdef FROST32_MEM_RESPONDER_ERR_CHECK_EN
    do_access(0, WR, S32, 32'h13, 32'h5555AAAA, rd, e, lat);
    check("misaligned write err", {31'h0, e}, 32'h1);
    check("err access latency", 32'(lat), 32'd2);
    do_access(0, RD, S32, 32'h10, 32'h0, rd, e, lat);
    check("word unchanged after err", rd, 32'hDEADBEEF);
    check("good read err low", {31'h0, e}, 32'h0);
    do_access(0, RD, SBAD, 32'h10, 32'h0, rd, e, lat);
    check("diasbad err", {31'h0, e}, 32'h1);
    check("diasbad data zero", rd, 32'h0);
    do_access(0, RD, S16, 32'h21, 32'h0, rd, e, lat);
    check("misaligned half err", {31'h0, e}, 32'h1);
    do_access(0, RD, S32, 32'h1000, 32'h0, rd, e, lat);
    check("out of range err", {31'h0, e}, 32'h1);
`else
    do_access(0, WR, S32, 32'h13, 32'h5555AAAA, rd, e, lat);
    check("low bits ignored err", {31'h0, e}, 32'h0);
    do_access(0, RD, S32, 32'h10, 32'h0, rd, e, lat);
    check("low bits ignored write", rd, 32'h5555AAAA);
    do_access(0, RD, SBAD, 32'h10, 32'h0, rd, e, lat);
    check("diasbad as word", rd, 32'h5555AAAA);
    do_access(0, RD, S16, 32'h13, 32'h0, rd, e, lat);
    check("half low bit ignored", rd, 32'h00005555);
`endif

    // WAIT_STATES=0: req held high across three reads
    held_exp = '{32'hA0A0A0A1, 32'hB0B0B0B2, 32'hC0C0C0C3};
    for (int i = 0; i < 3; i++)
      do_access(1, WR, S32, 32'h100 + 32'(4 * i), held_exp[i], rd, e, lat);
    do_access(1, RD, S32, 32'h100, 32'h0, rd, e, lat);
    check("ws0 latency", 32'(lat), 32'd1);
    @(negedge clk);
    type_s = RD; size_s = S32; addr_s = 32'h100; req[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("held ready %0d", i), {31'h0, rdy[1]}, 32'h1);
      check($sformatf("held data %0d", i), dout[1], held_exp[i]);
      type_s = WR; addr_s = 32'h100; din_s = 32'hFFFFFFFF;
      @(negedge clk);
      check($sformatf("held gap %0d", i), {31'h0, rdy[1]}, 32'h0);
      type_s = RD;
      if (i == 2) req[1] = 1'b0;
      else        addr_s = 32'h104 + 32'(4 * i);
    end
    do_access(1, RD, S32, 32'h100, 32'h0, rd, e, lat);
    check("busy-time write ignored", rd, 32'hA0A0A0A1);

    // WAIT_STATES=3: reset aborts a write in StWait
    do_access(2, WR, S32, 32'h40, 32'hCAFEF00D, rd, e, lat);
    check("ws3 latency", 32'(lat), 32'd4);
    do_access(2, RD, S32, 32'h40, 32'h0, rd, e, lat);
    check("ws3 read", rd, 32'hCAFEF00D);
    @(negedge clk);
    type_s = WR; size_s = S32; addr_s = 32'h40; din_s = 32'h0BADBEEF; req[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    check("ws3 busy in wait", {31'h0, bsy[2]}, 32'h1);
    @(negedge clk);
    #2 rstn[2] = 1'b0;
    #1;
    check("abort data_out", dout[2], 32'h0);
    check("abort busy", {31'h0, bsy[2]}, 32'h0);
    check("abort ready", {31'h0, rdy[2]}, 32'h0);
    check("abort err", {31'h0, er[2]}, 32'h0);
    @(negedge clk);
    rstn[2] = 1'b1;
    saw_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_rdy |= rdy[2];
    end
    check("no ready after abort", {31'h0, saw_rdy}, 32'h0);
    do_access(2, RD, S32, 32'h40, 32'h0, rd, e, lat);
    check("aborted write left RAM", rd, 32'hCAFEF00D);

    // WAIT_STATES=15: out-of-range address
    do_access(3, WR, S32, 32'h1000, 32'h12345678, rd, e, lat);
    check("ws15 write latency", 32'(lat), 32'd16);
`ifdef FROST32_MEM_RESPONDER_ERR_CHECK_EN
    check("ws15 range err", {31'h0, e}, 32'h1);
    do_access(3, RD, S32, 32'h1000, 32'h0, rd, e, lat);
    check("ws15 range read zero", rd, 32'h0);
`else
    do_access(3, RD, S32, 32'h0, 32'h0, rd, e, lat);
    check("ws15 wrap read", rd, 32'h12345678);
`endif
    check("ws15 read latency", 32'(lat), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
